burst_ram_arbiter: RTL and testbench

Two-port arbiter that shares one BurstRAM between the instruction cache (port B) and the data cache (port A). Each requester sees a private BurstRAM-style command interface. The arbiter latches one command per port, buffers write bursts, and grants the RAM round-robin. It replays the winning command to the RAM and steers the read burst back to its owner. It sits between the two Cache instances and the single BurstRAM instance.

---
 rtl/burst_ram_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
//   Shares one BurstRAM between two cache requesters (port A = data cache,
//   port B = instruction cache). Each port owns a single pending slot that
//   latches the command and, for writes, the whole burst of data/mask words.
//   Eligible slots are granted round-robin; the winner's command is replayed
//   to the RAM and the read burst is steered back to its owner.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   X_cmd/X_cmd_en/X_addr       per-port command (0 = read, 1 = write burst)
//   X_wr_data/X_data_mask       write words, word 0 in the X_cmd_en cycle
//   X_rd_data/X_rd_data_valid   read words, valid qualified by ownership
//   X_busy                      port has a pending or executing command
//   br_cmd/br_cmd_en/br_addr    RAM command side (registered)
//   br_wr_data/br_data_mask     RAM write words (registered)
//   br_rd_data/_valid, br_busy  RAM read return and busy flag
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 8,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    // port A
    input  logic                        a_cmd,
    input  logic                        a_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]   a_addr,
    input  logic [DATA_BITWIDTH-1:0]    a_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]  a_data_mask,
    output logic [DATA_BITWIDTH-1:0]    a_rd_data,
    output logic                        a_rd_data_valid,
    output logic                        a_busy,
    // port B
    input  logic                        b_cmd,
    input  logic                        b_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]   b_addr,
    input  logic [DATA_BITWIDTH-1:0]    b_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]  b_data_mask,
    output logic [DATA_BITWIDTH-1:0]    b_rd_data,
    output logic                        b_rd_data_valid,
    output logic                        b_busy,
    // RAM side
    output logic                        br_cmd,
    output logic                        br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]   br_addr,
    output logic [DATA_BITWIDTH-1:0]    br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]  br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]    br_rd_data,
    input  logic                        br_rd_data_valid,
    input  logic                        br_busy
);

    localparam int NUM_PORTS = 2;
    localparam int MASK_W    = DATA_BITWIDTH / 8;
    localparam int IDX_W     = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_COUNT - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    // Command head as seen by the grant logic: cmd, addr and word 0.
    typedef struct packed {
        logic                       cmd;
        logic [DEPTH_BITWIDTH-1:0]  addr;
        logic [DATA_BITWIDTH-1:0]   data;
        logic [MASK_W-1:0]          mask;
    } head_t;

    state_t                 state, state_n;
    logic                   owner;        // 0 = A, 1 = B
    logic                   last_grant;   // 0 = A, 1 = B
    logic [IDX_W-1:0]       beat;
    logic                   start;
    logic                   gnt;
    logic                   rd_ok;

    logic [NUM_PORTS-1:0]                       p_cmd_en, p_cmd;
    logic [NUM_PORTS-1:0][DEPTH_BITWIDTH-1:0]   p_addr;
    logic [NUM_PORTS-1:0][DATA_BITWIDTH-1:0]    p_wr_data;
    logic [NUM_PORTS-1:0][MASK_W-1:0]           p_mask;
    logic [NUM_PORTS-1:0]                       p_busy, p_elig, p_done;
    head_t [NUM_PORTS-1:0]                      head;
    logic [NUM_PORTS-1:0][BURST_COUNT-1:0][DATA_BITWIDTH-1:0] q_data;
    logic [NUM_PORTS-1:0][BURST_COUNT-1:0][MASK_W-1:0]        q_mask;

    assign p_cmd_en  = {b_cmd_en, a_cmd_en};
    assign p_cmd     = {b_cmd, a_cmd};
    assign p_addr    = {b_addr, a_addr};
    assign p_wr_data = {b_wr_data, a_wr_data};
    assign p_mask    = {b_data_mask, a_data_mask};

    // ------------------------------------------------------------------
    // Per-port pending slot
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic                                       pending;
        logic                                       capturing;
        logic [IDX_W-1:0]                           cap_idx;
        logic                                       cmd_q;
        logic [DEPTH_BITWIDTH-1:0]                  addr_q;
        logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0]  data_q;
        logic [BURST_COUNT-1:0][MASK_W-1:0]         mask_q;
        logic                                       fresh;

        assign fresh     = p_cmd_en[p] && !pending;
        assign p_busy[p] = pending;
        assign p_done[p] = (state == DRAIN) && !br_busy && (owner == 1'(p));

        // A fresh read (or single-word write) is granted straight from the
        // inputs so the RAM sees the command one cycle after X_cmd_en. A
        // write becomes eligible while its last word is still on the input;
        // that word is latched before WRITE needs it.
        assign p_elig[p] = fresh ? (!p_cmd[p] || (BURST_COUNT == 1))
                                 : (pending && (!capturing || cap_idx == LAST_IDX));

        assign head[p].cmd  = fresh ? p_cmd[p]     : cmd_q;
        assign head[p].addr = fresh ? p_addr[p]    : addr_q;
        assign head[p].data = fresh ? p_wr_data[p] : data_q[0];
        assign head[p].mask = fresh ? p_mask[p]    : mask_q[0];
        assign q_data[p]    = data_q;
        assign q_mask[p]    = mask_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pending   <= 1'b0;
                capturing <= 1'b0;
                cap_idx   <= '0;
                cmd_q     <= 1'b0;
                addr_q    <= '0;
                data_q    <= '0;
                mask_q    <= '0;
            end else begin
                if (p_done[p])
                    pending <= 1'b0;
                if (fresh) begin
                    pending   <= 1'b1;
                    cmd_q     <= p_cmd[p];
                    addr_q    <= p_addr[p];
                    data_q[0] <= p_wr_data[p];
                    mask_q[0] <= p_mask[p];
                    capturing <= p_cmd[p] && (BURST_COUNT > 1);
                    cap_idx   <= IDX_W'(1);
                end else if (capturing) begin
                    data_q[cap_idx] <= p_wr_data[p];
                    mask_q[cap_idx] <= p_mask[p];
                    cap_idx         <= cap_idx + IDX_W'(1);
                    if (cap_idx == LAST_IDX)
                        capturing <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin grant: B wins only if A is not eligible or A went last.
    // ------------------------------------------------------------------
    assign gnt   = p_elig[1] && (!p_elig[0] || !last_grant);
    assign start = (state == IDLE) && !br_busy && (|p_elig);

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start)
                       state_n = !head[gnt].cmd ? READ :
                                 (BURST_COUNT > 1) ? WRITE : DRAIN;
            WRITE: if (beat == LAST_IDX)
                       state_n = DRAIN;
            READ:  if (br_rd_data_valid && beat == LAST_IDX)
                       state_n = DRAIN;
            DRAIN: if (!br_busy)
                       state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered RAM command side
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            beat         <= '0;
            br_cmd_en    <= 1'b0;
            br_cmd       <= 1'b0;
            br_addr      <= '0;
            br_wr_data   <= '0;
            br_data_mask <= '0;
        end else begin
            state     <= state_n;
            br_cmd_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    owner        <= gnt;
                    last_grant   <= gnt;
                    br_cmd_en    <= 1'b1;
                    br_cmd       <= head[gnt].cmd;
                    br_addr      <= head[gnt].addr;
                    br_wr_data   <= head[gnt].cmd ? head[gnt].data : '0;
                    br_data_mask <= head[gnt].cmd ? head[gnt].mask : '0;
                    beat         <= head[gnt].cmd ? IDX_W'(1) : '0;
                end
                WRITE: begin
                    br_wr_data   <= q_data[owner][beat];
                    br_data_mask <= q_mask[owner][beat];
                    beat         <= beat + IDX_W'(1);
                end
                READ: if (br_rd_data_valid)
                    beat <= beat + IDX_W'(1);
                DRAIN: begin
                    br_wr_data   <= '0;
                    br_data_mask <= '0;
                    beat         <= '0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read return: data is broadcast, valid is steered to the owner only.
    // ------------------------------------------------------------------
    assign rd_ok           = (state == READ) && br_rd_data_valid;
    assign a_rd_data       = br_rd_data;
    assign b_rd_data       = br_rd_data;
    assign a_rd_data_valid = rd_ok && !owner;
    assign b_rd_data_valid = rd_ok && owner;
    assign a_busy          = p_busy[0];
    assign b_busy          = p_busy[1];

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small BurstRAM model whose
// contents start as mem[i] = i.
module tb_burst_ram_arbiter;
    localparam int AW = 8, DW = 64, BC = 4, MW = 8;

    logic clk = 1'b0, rst = 1'b0;
    logic a_cmd = 0, a_cmd_en = 0, b_cmd = 0, b_cmd_en = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wr_data = '0, b_wr_data = '0;
    logic [MW-1:0] a_data_mask = '0, b_data_mask = '0;
    logic [DW-1:0] a_rd_data, b_rd_data;
    logic a_rd_data_valid, b_rd_data_valid, a_busy, b_busy;
    logic br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [MW-1:0] br_data_mask;
    logic [DW-1:0] ram_rdata;
    logic ram_valid, ram_busy;

    always #5 clk = ~clk;

    burst_ram_arbiter #(.DEPTH_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
        .clk(clk), .rst(rst),
        .a_cmd(a_cmd), .a_cmd_en(a_cmd_en), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_data_mask(a_data_mask), .a_rd_data(a_rd_data), .a_rd_data_valid(a_rd_data_valid),
        .a_busy(a_busy),
        .b_cmd(b_cmd), .b_cmd_en(b_cmd_en), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_data_mask(b_data_mask), .b_rd_data(b_rd_data), .b_rd_data_valid(b_rd_data_valid),
        .b_busy(b_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
        .br_data_mask(br_data_mask), .br_rd_data(ram_rdata), .br_rd_data_valid(ram_valid),
        .br_busy(ram_busy)
    );

    // ---------------- BurstRAM model ----------------
    logic [DW-1:0] mem [256];
    logic rd_act, wr_act;
    logic [AW-1:0] r_addr, w_addr;
    int r_cnt, w_cnt, dly;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        for (int i = 0; i < MW; i++) if (m[i]) old[i*8 +: 8] = d[i*8 +: 8];
        return old;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
            ram_busy <= 0; ram_valid <= 0; ram_rdata <= '0;
            rd_act <= 0; wr_act <= 0; r_cnt <= 0; w_cnt <= 0; dly <= 0;
            r_addr <= '0; w_addr <= '0;
        end else begin
            ram_valid <= 1'b0;
            if (br_cmd_en) begin
                ram_busy <= 1'b1;
                if (br_cmd) begin
                    mem[br_addr] <= merge(mem[br_addr], br_wr_data, br_data_mask);
                    w_addr <= br_addr; w_cnt <= 1; wr_act <= 1'b1;
                end else begin
                    r_addr <= br_addr; r_cnt <= 0; dly <= 1; rd_act <= 1'b1;
                end
            end else if (wr_act) begin
                mem[AW'(w_addr + w_cnt)] <= merge(mem[AW'(w_addr + w_cnt)], br_wr_data, br_data_mask);
                w_cnt <= w_cnt + 1;
                if (w_cnt == BC - 1) begin wr_act <= 1'b0; ram_busy <= 1'b0; end
            end else if (rd_act) begin
                if (dly != 0) dly <= dly - 1;
                else if (r_cnt < BC) begin
                    ram_valid <= 1'b1;
                    ram_rdata <= mem[AW'(r_addr + r_cnt)];
                    r_cnt <= r_cnt + 1;
                end else begin
                    rd_act <= 1'b0; ram_busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            ev_cyc[$];
    logic [AW-1:0] ev_addr[$];
    logic          ev_cmd[$];
    logic          ev_pb[$];
    logic [DW-1:0] a_words[$], b_words[$], wr_words[$];
    logic [MW-1:0] wr_masks[$];
    int wr_left = 0, both_valid = 0, a_fall = -1;
    logic prev_busy = 0, prev_abusy = 0;

    always @(negedge clk) begin
        if (br_cmd_en) begin
            ev_cyc.push_back(cyc); ev_addr.push_back(br_addr);
            ev_cmd.push_back(br_cmd); ev_pb.push_back(prev_busy);
            if (br_cmd) wr_left = BC;
        end
        if (wr_left > 0) begin
            wr_words.push_back(br_wr_data); wr_masks.push_back(br_data_mask); wr_left--;
        end
        if (a_rd_data_valid) a_words.push_back(a_rd_data);
        if (b_rd_data_valid) b_words.push_back(b_rd_data);
        if (a_rd_data_valid && b_rd_data_valid) both_valid++;
        if (prev_abusy && !a_busy) a_fall = cyc;
        prev_busy = ram_busy; prev_abusy = a_busy;
    end

    // ---------------- helpers ----------------
    int n_vec = 0, n_err = 0;
    logic [DW-1:0] wdat [BC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        ev_cyc.delete(); ev_addr.delete(); ev_cmd.delete(); ev_pb.delete();
        a_words.delete(); b_words.delete(); wr_words.delete(); wr_masks.delete();
        both_valid = 0; a_fall = -1;
    endtask

    task automatic issue(input bit p, input logic c, input logic [AW-1:0] ad);
        for (int i = 0; i < (c ? BC : 1); i++) begin
            if (!p) begin
                a_cmd_en = (i == 0); a_cmd = c; a_addr = ad; a_wr_data = wdat[i]; a_data_mask = '1;
            end else begin
                b_cmd_en = (i == 0); b_cmd = c; b_addr = ad; b_wr_data = wdat[i]; b_data_mask = '1;
            end
            tick();
        end
        if (!p) begin a_cmd_en = 0; a_wr_data = '0; end
        else    begin b_cmd_en = 0; b_wr_data = '0; end
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        repeat (2) tick();
        while ((a_busy || b_busy || ram_busy) && n < 300) begin tick(); n++; end
        chk({tag, "_timeout"}, 64'(n < 300), 64'd1);
        repeat (2) tick();
    endtask

    task automatic req_loop(input bit p, input logic [AW-1:0] base);
        int n;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while ((p ? b_busy : a_busy) && n < 400) begin tick(); n++; end
            chk(p ? "fair_b_wait" : "fair_a_wait", 64'(n < 400), 64'd1);
            issue(p, 1'b0, base + AW'(k));
        end
    endtask

    // ---------------- stimulus ----------------
    int t0, seen, n;

    initial begin
        for (int i = 0; i < BC; i++) wdat[i] = 64'h1111 * (i + 1);

        // reset state
        repeat (3) tick();
        chk("rst_cmd_en", br_cmd_en, 0);
        chk("rst_addr", br_addr, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_a_vld", a_rd_data_valid, 0);
        rst = 1'b1;
        repeat (2) tick();

        // single read
        clr(); t0 = cyc;
        issue(0, 0, 8'h10);
        wait_done("rd");
        chk("rd_ncmd", ev_cyc.size(), 1);
        chk("rd_lat", ev_cyc[0], t0 + 1);
        chk("rd_addr", ev_addr[0], 8'h10);
        chk("rd_cmd", ev_cmd[0], 0);
        chk("rd_nwords", a_words.size(), BC);
        for (int i = 0; i < BC; i++) chk("rd_word", a_words[i], 64'h10 + i);
        chk("rd_b_quiet", b_words.size(), 0);
        chk("rd_busy_fall", a_fall, t0 + 9);

        // write then readback
        clr(); t0 = cyc;
        issue(1, 1, 8'h20);
        wait_done("wr");
        chk("wr_ncmd", ev_cyc.size(), 1);
        chk("wr_lat", ev_cyc[0], t0 + BC);
        chk("wr_cmd", ev_cmd[0], 1);
        chk("wr_addr", ev_addr[0], 8'h20);
        chk("wr_nwords", wr_words.size(), BC);
        for (int i = 0; i < BC; i++) begin
            chk("wr_word", wr_words[i], wdat[i]);
            chk("wr_mask", wr_masks[i], 8'hFF);
        end
        clr();
        issue(1, 0, 8'h20);
        wait_done("rb");
        chk("rb_nwords", b_words.size(), BC);
        for (int i = 0; i < BC; i++) chk("rb_word", b_words[i], wdat[i]);
        chk("rb_a_quiet", a_words.size(), 0);

        // contention
        clr(); t0 = cyc;
        a_cmd_en = 1; a_cmd = 0; a_addr = 8'h00;
        b_cmd_en = 1; b_cmd = 0; b_addr = 8'h40;
        tick();
        a_cmd_en = 0; b_cmd_en = 0;
        wait_done("ct");
        chk("ct_ncmd", ev_cyc.size(), 2);
        chk("ct_first", ev_addr[0], 8'h00);
        chk("ct_second", ev_addr[1], 8'h40);
        chk("ct_lat0", ev_cyc[0], t0 + 1);
        chk("ct_lat1", ev_cyc[1], t0 + 10);
        chk("ct_ram_idle", ev_pb[1], 0);
        chk("ct_a_n", a_words.size(), BC);
        chk("ct_b_n", b_words.size(), BC);
        for (int i = 0; i < BC; i++) begin
            chk("ct_a_word", a_words[i], 64'h00 + i);
            chk("ct_b_word", b_words[i], 64'h40 + i);
        end
        chk("ct_overlap", both_valid, 0);

        // fairness
        clr();
        fork
            req_loop(0, 8'h60);
            req_loop(1, 8'hA0);
        join
        wait_done("fair");
        chk("fair_ncmd", ev_cyc.size(), 6);
        for (int i = 0; i < 6; i++)
            chk("fair_order", ev_addr[i], (i % 2 == 0) ? 64'h60 + i / 2 : 64'hA0 + i / 2);
        chk("fair_a_n", a_words.size(), 3 * BC);
        chk("fair_b_n", b_words.size(), 3 * BC);
        chk("fair_overlap", both_valid, 0);

        // ignored command while busy
        clr();
        issue(1, 1, 8'h24);
        issue(0, 0, 8'h30);
        tick(); tick();
        chk("ign_busy", a_busy, 1);
        issue(0, 0, 8'h50);
        wait_done("ign");
        chk("ign_ncmd", ev_cyc.size(), 2);
        chk("ign_addr", ev_addr[1], 8'h30);
        chk("ign_cmd", ev_cmd[1], 0);
        chk("ign_nwords", a_words.size(), BC);
        chk("ign_w0", a_words[0], 64'h30);
        chk("ign_w3", a_words[BC-1], 64'h33);

        // reset during the 2nd read word
        clr();
        issue(0, 0, 8'h08);
        seen = 0; n = 0;
        while (seen < 2 && n < 50) begin
            if (a_rd_data_valid) seen++;
            if (seen < 2) tick();
            n++;
        end
        chk("rr_second_word", seen, 2);
        #2 rst = 1'b0;
        #1;
        chk("rr_vld", a_rd_data_valid, 0);
        chk("rr_b_vld", b_rd_data_valid, 0);
        chk("rr_busy", a_busy, 0);
        chk("rr_addr", br_addr, 0);
        chk("rr_cmd_en", br_cmd_en, 0);
        chk("rr_rdata", a_rd_data, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        clr(); t0 = cyc;
        issue(0, 0, 8'h08);
        wait_done("rr");
        chk("rr_ncmd", ev_cyc.size(), 1);
        chk("rr_lat", ev_cyc[0], t0 + 1);
        chk("rr_nwords", a_words.size(), BC);
        for (int i = 0; i < BC; i++) chk("rr_word", a_words[i], 64'h08 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
